// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner for a DIGITS-nibble hex value.
//   Scans one digit per DIV-cycle slot on a common-anode display.
//   At each frame start the whole value is snapshotted, so a frame never tears.
//   Optional leading-zero blanking, an enable, and configurable line polarity.
//   frame_done pulses on the cycle the scan wraps to digit 0.
// Optional feature macro: SEG_SCAN_DP_EN adds the dp_mask input and the dp output.
//   The decimal-point mask is snapshotted together with data.
// Ports:
//   clk        system clock, all logic on posedge
//   reset_n    synchronous active-low reset
//   en         1 = scan; 0 = display dark, scan held at start
//   data       value shown, nibble i -> digit i (digit 0 least significant)
//   blank_lz   1 = suppress leading zero digits
//   dp_mask    (SEG_SCAN_DP_EN) decimal point per digit
//   an         anode selects, one-hot when active (after polarity)
//   seg        segments {a,b,c,d,e,f,g}, MSB = a (after polarity)
//   dp         (SEG_SCAN_DP_EN) decimal point segment (segment polarity)
//   frame_done one-cycle pulse when the scan wraps to digit 0
module seg_scan_ctrl #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned DIV            = 2000,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank_lz,
`ifdef SEG_SCAN_DP_EN
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  dp,
`endif
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    // Inactive line levels; XOR with these applies the polarity.
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_snap;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_frame_done;

    logic              w_tick;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_frame_start;
    logic [3:0]        w_nib;
    logic              w_zero_sel;
    logic              w_blank;
    logic [DIGITS-1:0] w_an_act;
    logic [6:0]        w_seg_act;

    // Active-high abcdefg glyph for one hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // Slot timing and the digit index the next tick will show.
    always_comb begin
        w_tick        = en && (r_cnt == CNT_LAST);
        w_idx_nxt     = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        w_frame_start = (w_idx_nxt == '0);
    end

    // Render the upcoming digit; digit 0 comes straight from data since snap
    // is being reloaded on that same edge.
    always_comb begin
        w_nib      = data[3:0];
        w_zero_sel = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_nib      = r_snap[4*i +: 4];
                w_zero_sel = ((r_snap >> (4 * i)) == '0);
            end
        end
        w_blank   = blank_lz && w_zero_sel;
        w_an_act  = w_blank ? '0 : (DIGITS'(1) << w_idx_nxt);
        w_seg_act = w_blank ? '0 : glyph(w_nib);
    end

    // Prescaler, scan index, snapshot and registered display lines.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_idx        <= IDX_LAST;
            r_snap       <= '0;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_cnt        <= '0;
            r_idx        <= IDX_LAST;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_tick) begin
                r_cnt        <= '0;
                r_idx        <= w_idx_nxt;
                r_an         <= w_an_act ^ AN_OFF;
                r_seg        <= w_seg_act ^ SEG_OFF;
                r_frame_done <= w_frame_start;
                if (w_frame_start) begin
                    r_snap <= data;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0] r_dp_mask;
    logic              r_dp;
    logic              w_dp_act;

    // Decimal point follows the same snapshot and blanking as the digit.
    always_comb begin
        w_dp_act = dp_mask[0];
        for (int i = 1; i < DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_dp_act = r_dp_mask[i];
            end
        end
        w_dp_act = w_dp_act && !w_blank;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dp_mask <= '0;
            r_dp      <= SEG_ACTIVE_LOW;
        end else if (!en) begin
            r_dp      <= SEG_ACTIVE_LOW;
        end else if (w_tick) begin
            r_dp <= w_dp_act ^ SEG_ACTIVE_LOW;
            if (w_frame_start) begin
                r_dp_mask <= dp_mask;
            end
        end
    end

    assign dp = r_dp;
`endif

endmodule
